// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, mux select codes.
// Pure definitions: no timing and no flow control of its own.
package multi_cycle_control_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_I_EXEC   = 4'd10,
      S_I_WB     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   localparam logic [1:0] SRCB_REG    = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // Unknown opcodes fall back to FETCH; the caller raises fault for them.
   function automatic state_t decode_next(input logic [5:0] op);
      case (op)
         OP_RTYPE:     return S_R_EXEC;
         OP_LW, OP_SW: return S_MEM_ADDR;
         OP_BEQ:       return S_BRANCH;
         OP_J:         return S_JUMP;
         OP_ADDI:      return S_I_EXEC;
         default:      return S_FETCH;
      endcase
   endfunction

   function automatic logic op_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
   endfunction

   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory state waits for mem_ready; flags the last allowed cycle.
// timeout_o is combinational on wait_i in the TIMEOUT_CYCLES-th waiting cycle; counter self-clears.
module mem_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic wait_i,
   output logic timeout_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign timeout_o = wait_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // Leaving or re-entering a memory state always passes through a non-wait cycle or a timeout.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (!wait_i || timeout_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control FSM: fetch/decode/execute sequencing with memory wait and timeout.
// Memory states stall on mem_ready low; write enables are suppressed during reset and on timeout.
module multi_cycle_control
   import multi_cycle_control_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       fault
);

   state_t state_q, state_d;
   logic   fault_q, fault_d;
   logic   timeout;

   mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clock     (clock),
      .reset     (reset),
      .wait_i    (is_mem_state(state_q) && !mem_ready),
      .timeout_o (timeout)
   );

   assign state = state_q;
   assign fault = fault_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      fault_d       = fault_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALU_ADD;
      pc_source     = PCSRC_ALU;
      instr_done    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout) begin
               fault_d = 1'b1;
            end
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            state_d   = decode_next(opcode);
            if (!op_legal(opcode)) begin
               fault_d = 1'b1;
            end
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) begin
               state_d = S_MEM_WB;
            end else if (timeout) begin
               state_d = S_FETCH;
               fault_d = 1'b1;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write = !timeout;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (timeout) begin
               state_d = S_FETCH;
               fault_d = 1'b1;
            end
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
            state_d   = S_R_WB;
         end
         S_R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            instr_done    = 1'b1;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = PCSRC_JUMP;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = S_I_WB;
         end
         S_I_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      if (reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
         mem_write     = 1'b0;
         instr_done    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed and randomized instruction sequences checked cycle by cycle against a per-instruction path model.
module tb_multi_cycle_control;

   logic       clock;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;
   logic       instr_done, fault;

   int vectors     = 0;
   int miscompares = 0;
   int done_seen   = 0;
   bit exp_fault   = 0;

   multi_cycle_control dut (
      .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .state(state), .instr_done(instr_done), .fault(fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic bit legal(input logic [5:0] op);
      return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
             op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
   endfunction

   // Control word a state should present, straight from the per-state output table.
   function automatic logic [21:0] expect_word(input int st, input bit rdy, input bit to,
                                               input bit rst, input bit flt);
      logic pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, asa, done;
      logic [1:0] asb, aop, psrc;
      {pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, asa, done} = '0;
      asb = 2'd0; aop = 2'd0; psrc = 2'd0;
      case (st)
         0:  begin mr = 1; asb = 2'd1; irw = rdy; pcw = rdy; end
         1:  asb = 2'd3;
         2:  begin asa = 1; asb = 2'd2; end
         3:  begin mr = 1; iod = 1; end
         4:  begin rw = 1; m2r = 1; done = 1; end
         5:  begin mw = !to; iod = 1; done = rdy; end
         6:  begin asa = 1; aop = 2'd2; end
         7:  begin rw = 1; rd = 1; done = 1; end
         8:  begin asa = 1; aop = 2'd1; pcwc = 1; psrc = 2'd1; done = 1; end
         9:  begin pcw = 1; psrc = 2'd2; done = 1; end
         10: begin asa = 1; asb = 2'd2; end
         11: begin rw = 1; done = 1; end
         default: ;
      endcase
      if (rst) {pcw, pcwc, irw, rw, mw, done} = '0;
      return {pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, 4'(st), done, flt};
   endfunction

   task automatic check_cycle(input int st, input bit rdy, input bit to, input bit rst,
                              input string tag);
      logic [21:0] obs, exp;
      mem_ready = rdy;
      reset     = rst;
      @(negedge clock);
      obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state,
             instr_done, fault};
      exp = expect_word(st, rdy, to, rst, exp_fault);
      done_seen += int'(instr_done);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: state %0d observed %h expected %h", tag, st, obs, exp);
      end
      @(posedge clock);
      #1;
   endtask

   // One instruction: wf/wm = cycles mem_ready stays low in FETCH / data access (>=16 times out),
   // rst_k = wait cycle of the data access on which reset is asserted (-1 for none).
   task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int rst_k,
                            input string tag);
      int path[$];
      bit aborted;
      int exp_done;
      aborted   = 0;
      done_seen = 0;
      opcode    = op;
      case (op)
         6'b000000: path = '{0, 1, 6, 7};
         6'b100011: path = '{0, 1, 2, 3, 4};
         6'b101011: path = '{0, 1, 2, 5};
         6'b000100: path = '{0, 1, 8};
         6'b000010: path = '{0, 1, 9};
         6'b001000: path = '{0, 1, 10, 11};
         default:   path = '{0, 1};
      endcase
      for (int i = 0; i < path.size() && !aborted; i++) begin
         int s;
         s = path[i];
         if (s == 0 || s == 3 || s == 5) begin
            for (int k = 0; k < 16; k++) begin
               bit rdy, to, rst;
               rdy = (k == ((s == 0) ? wf : wm));
               to  = (k == 15) && !rdy;
               rst = (s != 0) && (k == rst_k);
               check_cycle(s, rdy, to, rst, tag);
               if (rst) begin reset = 0; exp_fault = 0; aborted = 1; break; end
               if (to)  begin exp_fault = 1; aborted = 1; break; end
               if (rdy) break;
            end
         end else begin
            check_cycle(s, 1'($urandom_range(0, 1)), 1'b0, 1'b0, tag);
            if (s == 1 && !legal(op)) exp_fault = 1;
         end
      end
      exp_done = (aborted || !legal(op)) ? 0 : 1;
      vectors++;
      assert (done_seen === exp_done) else begin
         miscompares++;
         $error("FAIL %s_done: observed %0d pulses expected %0d", tag, done_seen, exp_done);
      end
   endtask

   task automatic do_reset(input string tag);
      check_cycle(0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, tag);
      reset     = 0;
      exp_fault = 0;
   endtask

   function automatic logic [5:0] pick_op(input int idx);
      case (idx)
         0: return 6'b000000;
         1: return 6'b100011;
         2: return 6'b101011;
         3: return 6'b000100;
         4: return 6'b000010;
         5: return 6'b001000;
         6: return 6'b111111;
         7: return 6'b000001;
         default: return 6'b100000;
      endcase
   endfunction

   initial begin
      reset     = 1;
      mem_ready = 0;
      opcode    = 6'b000000;
      @(posedge clock);
      #1;
      do_reset("reset_state");

      run_instr(6'b000000, 0, 0, -1, "rtype");
      run_instr(6'b100011, 0, 3, -1, "lw_wait3");
      run_instr(6'b101011, 2, 1, -1, "sw_wait");
      run_instr(6'b001000, 1, 0, -1, "addi");
      run_instr(6'b111111, 0, 0, -1, "illegal");
      run_instr(6'b001000, 0, 0, -1, "fault_sticky");
      do_reset("reset_clr_fault");
      run_instr(6'b000000, 16, 0, -1, "fetch_timeout");
      run_instr(6'b000100, 0, 0, -1, "after_fetch_to");
      do_reset("reset_after_to");
      run_instr(6'b101011, 0, 20, 4, "sw_reset_midwait");
      run_instr(6'b000000, 15, 0, -1, "fetch_wait15");
      run_instr(6'b100011, 0, 15, -1, "lw_wait15");
      run_instr(6'b000100, 0, 0, -1, "beq");
      run_instr(6'b000010, 0, 0, -1, "jump");
      run_instr(6'b101011, 0, 16, -1, "sw_timeout");
      do_reset("reset_after_sw_to");
      run_instr(6'b100011, 0, 16, -1, "lw_timeout");
      do_reset("reset_after_lw_to");

      for (int n = 0; n < 60; n++) begin
         logic [5:0] op;
         int wf, wm;
         op = pick_op($urandom_range(0, 8));
         wf = ($urandom_range(0, 11) == 0) ? 16 : int'($urandom_range(0, 3));
         wm = ($urandom_range(0, 11) == 0) ? 16 : int'($urandom_range(0, 3));
         run_instr(op, wf, wm, -1, "rand");
         if (exp_fault && $urandom_range(0, 2) == 0) do_reset("rand_reset");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, maximum cycles a memory state waits for mem_ready before aborting.
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1: single clock; all state changes on its rising edge.
- reset, in, 1: synchronous, active-high.
- opcode, in, 6: instruction-register opcode field, valid from DECODE onward.
- mem_ready, in, 1: memory completes the current access this cycle.
- pc_write, out, 1: unconditional PC load.
- pc_write_cond, out, 1: PC load if ALU zero.
- i_or_d, out, 1: memory address source, 0 = PC, 1 = ALUOut.
- mem_read, out, 1: memory read request.
- mem_write, out, 1: memory write request.
- ir_write, out, 1: instruction register load.
- mem_to_reg, out, 1: write-back source, 1 = MDR.
- reg_dst, out, 1: destination register, 1 = rd.
- reg_write, out, 1: register file write.
- alu_src_a, out, 1: ALU A input, 1 = register A.
- alu_src_b, out, 2: ALU B input, 0 = B, 1 = const 4, 2 = sign-extended immediate, 3 = shifted immediate.
- alu_op, out, 2: 0 = add, 1 = subtract, 2 = funct-decoded.
- pc_source, out, 2: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- state, out, 4: current state encoding.
- instr_done, out, 1: one-cycle pulse when an instruction retires.
- fault, out, 1: sticky error flag.

Function
REQ-003 States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
REQ-004 DECODE transitions by opcode:
- 000000 -> R_EXEC; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> I_EXEC.
- Any other opcode -> FETCH, with fault set.
REQ-005 Other transitions:
- MEM_ADDR -> MEM_RD (lw) or MEM_WR (sw); MEM_RD -> MEM_WB; R_EXEC -> R_WB; I_EXEC -> I_WB.
- MEM_WB, MEM_WR, R_WB, I_WB, BRANCH and JUMP all -> FETCH.
REQ-006 Memory wait: FETCH, MEM_RD and MEM_WR hold mem_read/mem_write high and remain in state until mem_ready=1; they advance on the edge ending the mem_ready cycle.
REQ-007 FETCH outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0; ir_write and pc_write assert only in the cycle mem_ready=1.
REQ-008 DECODE outputs: alu_src_a=0, alu_src_b=3, alu_op=0 (branch-target precompute); no write enables.
REQ-009 Address and load/store outputs:
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0.
- MEM_RD: mem_read=1, i_or_d=1.
- MEM_WR: mem_write=1, i_or_d=1.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-010 Execute and write-back outputs:
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=2.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
- I_EXEC: alu_src_a=1, alu_src_b=2, alu_op=0.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-011 Branch and jump outputs:
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1.
- JUMP: pc_write=1, pc_source=2.
REQ-012 Outputs not listed for a state SHALL be 0.
REQ-013 instr_done SHALL pulse in the cycle the FSM is in MEM_WB, MEM_WR with mem_ready=1, R_WB, I_WB, BRANCH or JUMP.
REQ-014 Minimum latencies with mem_ready tied high: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
REQ-015 Timeout: a wait counter clears on entry to each memory state. If it reaches TIMEOUT_CYCLES without mem_ready, the FSM returns to FETCH, sets fault, and drives no write enable that cycle.
REQ-016 fault clears only on reset.

Reset
REQ-017 When reset=1 on a clock edge, the FSM SHALL enter FETCH, clear fault and the wait counter, and force instr_done=0. This applies in any state, including mid-wait.
REQ-018 While reset is high, all write enables (pc_write, pc_write_cond, ir_write, reg_write, mem_write) SHALL be 0.

Structure
REQ-019 A shared package SHALL hold the state encodings, opcode constants, and the alu_op, alu_src_b and pc_source codes.
REQ-020 The block SHALL contain one sub-module, mem_wait_timer, which holds the wait counter and timeout compare.

Verification
REQ-021 Reset, then opcode=000000 with mem_ready=1: states 0,1,6,7,0; reg_write=1 and reg_dst=1 in the state-7 cycle; instr_done pulses once.
REQ-022 opcode=100011, with mem_ready low for 3 cycles in MEM_RD: MEM_RD lasts 4 cycles with mem_read=1 and i_or_d=1; then MEM_WB with mem_to_reg=1.
REQ-023 opcode=111111: DECODE -> FETCH; fault=1 persists until reset; instr_done stays 0.
REQ-024 mem_ready held low for 16 cycles in FETCH: return to FETCH with fault=1; ir_write is never asserted.
REQ-025 Reset asserted during MEM_WR wait: next state FETCH, mem_write=0, fault=0.
REQ-026 opcode=000100, then 000010: BRANCH with pc_write_cond=1 and alu_op=1; JUMP with pc_write=1 and pc_source=2; each takes 3 cycles.
